uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter feeding one byte-wide UART transmitter.
// Ownership is locked from FETCH until the last byte completes or the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int GAP_CYCLES   = 0,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   uart_transmit,
  output logic [7:0]             uart_tx_byte,
  input  logic                   uart_is_transmitting,
  output logic                   busy,
  output logic                   msg_done
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [GAP_W-1:0]   GAP_END = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]    TO_END  = TO_W'(HOLD_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [OWN_W-1:0]   r_owner;
  logic [OWN_W-1:0]   r_last_owner;
  logic               r_last;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_transmit;
  logic [7:0]         r_tx_byte;
  logic               r_msg_done;

  logic [OWN_W-1:0]   w_pick;
  logic [OWN_W-1:0]   w_idx;
  logic               w_found;
  logic [7:0]         w_own_data;
  logic               w_own_valid;
  logic               w_own_last;
  logic               w_timeout;
  logic               w_byte_end;
  logic               w_release;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = OWN_W'((int'(r_last_owner) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_own_data = req_data[8*i +: 8];
    end
  end

  assign w_own_valid = |(req_valid & r_grant);
  assign w_own_last  = |(req_last & r_grant);
  assign w_timeout   = (r_state == FETCH) && !w_own_valid && (r_to_cnt == TO_END);
  assign w_byte_end  = ((r_state == WAIT_DONE) && !uart_is_transmitting && (GAP_CYCLES == 0)) ||
                       ((r_state == GAP) && (r_gap_cnt == GAP_END));
  assign w_release   = w_timeout || (w_byte_end && r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= OWN_W'(NUM_REQ - 1);
      r_last       <= 1'b0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
      r_transmit   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_msg_done   <= 1'b0;
    end else begin
      r_transmit <= 1'b0;
      r_msg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= ONE << w_pick;
            r_owner <= w_pick;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (w_own_valid) begin
            r_tx_byte  <= w_own_data;
            r_last     <= w_own_last;
            r_to_cnt   <= '0;
            r_transmit <= 1'b1;
            r_state    <= START;
          end else if (!w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        START:     r_state <= WAIT_BUSY;
        WAIT_BUSY: if (uart_is_transmitting) r_state <= WAIT_DONE;
        WAIT_DONE: if (!uart_is_transmitting && (GAP_CYCLES > 0)) r_state <= GAP;
        GAP: begin
          if (r_gap_cnt == GAP_END) r_gap_cnt <= '0;
          else                      r_gap_cnt <= r_gap_cnt + 1'b1;
        end
        default:   r_state <= IDLE;
      endcase

      // Post-byte decision and stall timeout share the release path.
      if (w_byte_end && !r_last) r_state <= FETCH;
      if (w_release) begin
        r_msg_done   <= 1'b1;
        r_last_owner <= r_owner;
        r_grant      <= '0;
        r_to_cnt     <= '0;
        r_state      <= IDLE;
      end
    end
  end

  assign grant         = r_grant;
  assign req_ready     = (r_state == FETCH) ? r_grant : '0;
  assign uart_transmit = r_transmit;
  assign uart_tx_byte  = r_tx_byte;
  assign busy          = (r_state != IDLE);
  assign msg_done      = r_msg_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, a behavioural UART responder,
// GAP_CYCLES=5 and HOLD_TIMEOUT=16.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_last, req_ready, grant;
  logic [15:0] req_data;
  logic        uart_transmit, uart_is_transmitting, busy, msg_done;
  logic [7:0]  uart_tx_byte;

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(5), .HOLD_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .busy(busy), .msg_done(msg_done)
  );

  int n_total = 0, n_bad = 0, cyc = 0;
  int n_done, n_stall, gap_meas, t_fall, overlap;
  logic [8:0] q0[$], q1[$];
  logic [7:0] txlog[$];
  logic [1:0] glog[$];
  logic [1:0] prev_grant, acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // UART responder: busy for three half-cycle-aligned clocks after each strobe.
  initial begin
    uart_is_transmitting = 1'b0;
    overlap = 0;
    t_fall = 0;
    forever begin
      @(negedge clk);
      if (uart_transmit === 1'b1) begin
        txlog.push_back(uart_tx_byte);
        uart_is_transmitting = 1'b1;
        for (int k = 0; k < 3 && rst_n; k++) begin
          @(negedge clk);
          if (uart_transmit === 1'b1) overlap++;
        end
        uart_is_transmitting = 1'b0;
        t_fall = cyc;
      end
    end
  end

  task automatic push(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (r == 0) q0.push_back({(i == s.len() - 1), s[i]});
      else        q1.push_back({(i == s.len() - 1), s[i]});
    end
  endtask

  task automatic run(input int n);
    logic [8:0] tmp;
    for (int c = 0; c < n; c++) begin
      if (msg_done) n_done++;
      if (grant != prev_grant) begin
        glog.push_back(grant);
        prev_grant = grant;
      end
      if (acc[0]) tmp = q0.pop_front();
      if (acc[1]) tmp = q1.pop_front();
      req_valid = {q1.size() > 0, q0.size() > 0};
      req_data  = '0;
      req_last  = '0;
      if (q0.size() > 0) begin req_data[7:0]  = q0[0][7:0]; req_last[0] = q0[0][8]; end
      if (q1.size() > 0) begin req_data[15:8] = q1[0][7:0]; req_last[1] = q1[0][8]; end
      acc = req_valid & req_ready;
      if (req_ready != 2'b00 && acc == 2'b00) n_stall++;
      if (acc != 2'b00) gap_meas = cyc - t_fall;
      @(negedge clk);
    end
  endtask

  task automatic start_test();
    txlog.delete();
    glog.delete();
    prev_grant = grant;
    n_done = 0;
    n_stall = 0;
    gap_meas = -1;
  endtask

  task automatic chk_tx(input string tag, input string exp);
    check_val({tag, "_len"}, txlog.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check_val($sformatf("%s_byte%0d", tag, i),
                (i < txlog.size()) ? 32'(txlog[i]) : 32'hFFFF, 32'(exp[i]));
  endtask

  task automatic chk_g(input string tag, input int i, input logic [1:0] e);
    check_val($sformatf("%s_grant%0d", tag, i),
              (i < glog.size()) ? 32'(glog[i]) : 32'hEE, 32'(e));
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    acc = '0; prev_grant = '0;
    repeat (3) @(negedge clk);
    check_val("rst_grant", grant, 2'b00);
    check_val("rst_ready", req_ready, 2'b00);
    check_val("rst_xmit", uart_transmit, 1'b0);
    check_val("rst_byte", uart_tx_byte, 8'h00);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", msg_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester 1, one byte: grant/ready at N+1, strobe at N+2.
    start_test();
    req_data = 16'h5100; req_last = 2'b10; req_valid = 2'b10;
    @(negedge clk);
    check_val("lat_grant", grant, 2'b10);
    check_val("lat_ready", req_ready, 2'b10);
    check_val("lat_busy", busy, 1'b1);
    check_val("lat_xmit_early", uart_transmit, 1'b0);
    @(negedge clk);
    check_val("lat_xmit", uart_transmit, 1'b1);
    check_val("lat_byte", uart_tx_byte, 8'h51);
    req_valid = 2'b00; req_last = 2'b00; req_data = '0;
    @(negedge clk);
    check_val("lat_xmit_once", uart_transmit, 1'b0);
    run(40);
    check_val("lat_msgdone", n_done, 1);
    chk_tx("lat", "Q");

    // Both requesters with 3-byte messages.
    start_test();
    push(0, "abc");
    push(1, "xyz");
    run(160);
    chk_tx("fair", "abcxyz");
    check_val("fair_msgdone", n_done, 2);
    chk_g("fair", 0, 2'b01);
    chk_g("fair", 1, 2'b00);
    chk_g("fair", 2, 2'b10);

    // Requester 0 arrives mid-message of requester 1: no interleave.
    start_test();
    push(1, "Hi\n");
    run(8);
    push(0, "Z");
    run(120);
    chk_tx("lock", "Hi\nZ");
    check_val("lock_msgdone", n_done, 2);
    chk_g("lock", 0, 2'b10);
    chk_g("lock", 1, 2'b00);
    chk_g("lock", 2, 2'b01);

    // Inter-byte gap: 5 GAP clocks plus the FETCH clock.
    start_test();
    push(0, "gh");
    run(60);
    check_val("gap_cycles", gap_meas, 6);
    chk_tx("gap", "gh");
    check_val("gap_msgdone", n_done, 1);

    // Owner 1 stalls after its first byte: released after 16 FETCH clocks.
    start_test();
    q1.push_back({1'b0, 8'h70});
    push(0, "r");
    run(100);
    check_val("hold_stall", n_stall, 16);
    check_val("hold_msgdone", n_done, 2);
    chk_tx("hold", "pr");
    chk_g("hold", 0, 2'b10);
    chk_g("hold", 1, 2'b00);
    chk_g("hold", 2, 2'b01);

    // Reset during WAIT_DONE aborts the message; requester 0 regains priority.
    start_test();
    push(1, "mn");
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      run(1);
      if (uart_is_transmitting) begin
        seen = 1;
        break;
      end
    end
    check_val("arst_reach", seen, 1);
    run(2);
    rst_n = 1'b0;
    #1;
    check_val("arst_grant", grant, 2'b00);
    check_val("arst_ready", req_ready, 2'b00);
    check_val("arst_xmit", uart_transmit, 1'b0);
    check_val("arst_byte", uart_tx_byte, 8'h00);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_done", msg_done, 1'b0);
    q0.delete(); q1.delete();
    acc = '0; req_valid = '0; req_last = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_test();
    run(6);
    check_val("arst_abort", txlog.size(), 0);
    push(1, "u");
    push(0, "v");
    run(60);
    chk_g("arst_prio", 0, 2'b01);
    chk_tx("arst", "vu");

    check_val("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
